// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command parser.
package uart_cmd_parser_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_WR         = 8'h01;
  localparam logic [7:0] CMD_RD         = 8'h02;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BAD_CMD = 3'd1;
  localparam logic [2:0] ERR_BAD_CHK = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CHK,
    ST_HOLD
  } state_t;

  // Frame checksum: XOR of the cmd, addr and data bytes.
  function automatic logic [7:0] calc_chk(input logic [7:0] c, input logic [7:0] a,
                                          input logic [7:0] d);
    return c ^ a ^ d;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Register-access command handshake from the parser to the I2C master control logic.
interface uart_cmd_parser_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_rw, output cmd_addr, output cmd_data,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rw, input cmd_addr, input cmd_data,
                  output cmd_ready);
endinterface

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: counts while enabled, restarts on clear, and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1 without a clear.
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 156250,
  parameter int TMR_W          = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_reg;

  // A clear in the final cycle wins over expiry: the byte arrived in time.
  assign expire = enable && !clear && (count_reg == LAST);

  // Counter restarts on clear, when idle, and after firing so it never overruns LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear || !enable || expire) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte frames (header, cmd, addr, data, checksum) from the UART
// receiver into register-access commands with a valid/ready handshake.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 156250,
  parameter int         TMR_W          = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_done,
  input  logic [7:0]          rx_data,
  uart_cmd_parser_if.master   cmd,
  output logic                err,
  output logic [2:0]          err_code,
  output logic [15:0]         frame_cnt
);

  state_t      state_reg;
  logic [7:0]  cmd_byte_reg;
  logic        rw_reg;
  logic [7:0]  addr_reg;
  logic [7:0]  data_reg;
  logic        cmd_valid_reg;
  logic        cmd_rw_reg;
  logic [7:0]  cmd_addr_reg;
  logic [7:0]  cmd_data_reg;
  logic        err_reg;
  logic [2:0]  err_code_reg;
  logic [15:0] frame_cnt_reg;
  logic        tmr_en;
  logic        tmr_expire;

  // The watchdog only runs while a frame is partially received.
  assign tmr_en = (state_reg == ST_GET_CMD) || (state_reg == ST_GET_ADDR) ||
                  (state_reg == ST_GET_DATA) || (state_reg == ST_GET_CHK);

  uart_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_done),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  // Frame FSM with field capture, checksum check, command hold and error reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cmd_byte_reg  <= '0;
      rw_reg        <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_rw_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_data_reg  <= '0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
      frame_cnt_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      // Expiry only fires without rx_done, so it never competes with a byte.
      if (tmr_expire) begin
        err_reg      <= 1'b1;
        err_code_reg <= ERR_TIMEOUT;
        state_reg    <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (rx_done && rx_data == HEADER) state_reg <= ST_GET_CMD;
          end
          ST_GET_CMD: begin
            if (rx_done) begin
              if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                cmd_byte_reg <= rx_data;
                rw_reg       <= (rx_data == CMD_RD);
                state_reg    <= ST_GET_ADDR;
              end else begin
                err_reg      <= 1'b1;
                err_code_reg <= ERR_BAD_CMD;
                state_reg    <= ST_IDLE;
              end
            end
          end
          ST_GET_ADDR: begin
            if (rx_done) begin
              addr_reg  <= rx_data;
              state_reg <= ST_GET_DATA;
            end
          end
          ST_GET_DATA: begin
            if (rx_done) begin
              data_reg  <= rx_data;
              state_reg <= ST_GET_CHK;
            end
          end
          ST_GET_CHK: begin
            if (rx_done) begin
              if (rx_data == calc_chk(cmd_byte_reg, addr_reg, data_reg)) begin
                cmd_valid_reg <= 1'b1;
                cmd_rw_reg    <= rw_reg;
                cmd_addr_reg  <= addr_reg;
                cmd_data_reg  <= data_reg;
                state_reg     <= ST_HOLD;
              end else begin
                err_reg      <= 1'b1;
                err_code_reg <= ERR_BAD_CHK;
                state_reg    <= ST_IDLE;
              end
            end
          end
          ST_HOLD: begin
            // A byte arriving with acceptance is handled as if already idle.
            if (cmd.cmd_ready) begin
              cmd_valid_reg <= 1'b0;
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
              state_reg     <= (rx_done && rx_data == HEADER) ? ST_GET_CMD : ST_IDLE;
            end else if (rx_done) begin
              err_reg      <= 1'b1;
              err_code_reg <= ERR_OVERRUN;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd.cmd_valid = cmd_valid_reg;
  assign cmd.cmd_rw    = cmd_rw_reg;
  assign cmd.cmd_addr  = cmd_addr_reg;
  assign cmd.cmd_data  = cmd_data_reg;
  assign err           = err_reg;
  assign err_code      = err_code_reg;
  assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with hand-computed expectations.
module tb_uart_cmd_parser;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .HEADER         (8'hA5),
    .TIMEOUT_CYCLES (T),
    .TMR_W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .cmd       (bus),
    .err       (err),
    .err_code  (err_code),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Counts clock cycles in which err is high.
  always @(posedge clk) if (err) err_seen++;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0); idle(2);
    send_byte(b1); idle(2);
    send_byte(b2); idle(2);
    send_byte(b3); idle(2);
    send_byte(b4);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_val({tag, "_valid"}, 32'(bus.cmd_valid), 32'd0);
    chk_val({tag, "_rw"},    32'(bus.cmd_rw),    32'd0);
    chk_val({tag, "_addr"},  32'(bus.cmd_addr),  32'd0);
    chk_val({tag, "_data"},  32'(bus.cmd_data),  32'd0);
    chk_val({tag, "_err"},   32'(err),           32'd0);
    chk_val({tag, "_code"},  32'(err_code),      32'd0);
    chk_val({tag, "_fcnt"},  32'(frame_cnt),     32'd0);
  endtask

  initial begin
    int e0;
    int stable;
    bus.cmd_ready = 1'b0;

    // Reset
    rst = 1'b1;
    idle(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    idle(2);

    // Write frame with consumer ready
    bus.cmd_ready = 1'b1;
    e0 = err_seen;
    send_frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    chk_val("wr_valid", 32'(bus.cmd_valid), 32'd1);
    chk_val("wr_rw",    32'(bus.cmd_rw),    32'd0);
    chk_val("wr_addr",  32'(bus.cmd_addr),  32'h10);
    chk_val("wr_data",  32'(bus.cmd_data),  32'h3C);
    tick();
    chk_val("wr_valid_drop", 32'(bus.cmd_valid), 32'd0);
    chk_val("wr_fcnt",  32'(frame_cnt), 32'd1);
    chk_val("wr_no_err", 32'(err_seen - e0), 32'd0);
    idle(2);

    // Read frame with 100 cycles of backpressure
    bus.cmd_ready = 1'b0;
    send_frame(8'hA5, 8'h02, 8'h20, 8'h00, 8'h22);
    chk_val("rd_valid", 32'(bus.cmd_valid), 32'd1);
    chk_val("rd_rw",    32'(bus.cmd_rw),    32'd1);
    chk_val("rd_addr",  32'(bus.cmd_addr),  32'h20);
    stable = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.cmd_valid !== 1'b1 || bus.cmd_rw !== 1'b1 || bus.cmd_addr !== 8'h20 ||
          bus.cmd_data !== 8'h00) stable = 0;
    end
    chk_val("rd_stable", 32'(stable), 32'd1);
    chk_val("rd_fcnt_hold", 32'(frame_cnt), 32'd1);
    bus.cmd_ready = 1'b1;
    tick();
    chk_val("rd_valid_drop", 32'(bus.cmd_valid), 32'd0);
    chk_val("rd_fcnt", 32'(frame_cnt), 32'd2);
    idle(2);

    // Bad checksum
    send_frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00);
    chk_val("chk_err",  32'(err),      32'd1);
    chk_val("chk_code", 32'(err_code), 32'd2);
    chk_val("chk_valid", 32'(bus.cmd_valid), 32'd0);
    tick();
    chk_val("chk_err_pulse", 32'(err), 32'd0);
    chk_val("chk_code_held", 32'(err_code), 32'd2);
    idle(2);

    // Bad command
    send_byte(8'hA5); idle(2);
    send_byte(8'h07);
    chk_val("cmd_err",  32'(err),      32'd1);
    chk_val("cmd_code", 32'(err_code), 32'd1);
    idle(2);

    // Junk before a good frame
    e0 = err_seen;
    send_byte(8'h00); idle(1);
    send_byte(8'hFF); idle(1);
    send_byte(8'h5A); idle(1);
    send_frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    chk_val("junk_valid", 32'(bus.cmd_valid), 32'd1);
    tick();
    chk_val("junk_fcnt", 32'(frame_cnt), 32'd3);
    chk_val("junk_no_err", 32'(err_seen - e0), 32'd0);
    idle(2);

    // Timeout: err exactly T cycles after the last byte
    send_byte(8'hA5); idle(2);
    send_byte(8'h01);
    idle(T - 1);
    chk_val("to_early", 32'(err), 32'd0);
    tick();
    chk_val("to_err",  32'(err),      32'd1);
    chk_val("to_code", 32'(err_code), 32'd3);
    idle(2);
    send_frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    chk_val("to_after_valid", 32'(bus.cmd_valid), 32'd1);
    tick();
    chk_val("to_after_fcnt", 32'(frame_cnt), 32'd4);
    idle(2);

    // Overrun while holding, then byte coincident with acceptance
    bus.cmd_ready = 1'b0;
    send_frame(8'hA5, 8'h02, 8'h44, 8'h55, 8'h13);
    chk_val("ovr_valid", 32'(bus.cmd_valid), 32'd1);
    idle(3);
    send_byte(8'h33);
    chk_val("ovr_err",   32'(err),           32'd1);
    chk_val("ovr_code",  32'(err_code),      32'd4);
    chk_val("ovr_valid_kept", 32'(bus.cmd_valid), 32'd1);
    chk_val("ovr_addr",  32'(bus.cmd_addr),  32'h44);
    chk_val("ovr_data",  32'(bus.cmd_data),  32'h55);
    chk_val("ovr_rw",    32'(bus.cmd_rw),    32'd1);
    idle(2);
    bus.cmd_ready = 1'b1;
    e0 = err_seen;
    send_byte(8'hA5);
    chk_val("acc_valid_drop", 32'(bus.cmd_valid), 32'd0);
    chk_val("acc_fcnt", 32'(frame_cnt), 32'd5);
    idle(2);
    send_byte(8'h01); idle(2);
    send_byte(8'h10); idle(2);
    send_byte(8'h3C); idle(2);
    send_byte(8'h2D);
    chk_val("acc_next_valid", 32'(bus.cmd_valid), 32'd1);
    tick();
    chk_val("acc_next_fcnt", 32'(frame_cnt), 32'd6);
    chk_val("acc_no_err", 32'(err_seen - e0), 32'd0);
    idle(2);

    // Byte arriving in the expiry cycle wins over the timeout
    e0 = err_seen;
    send_byte(8'hA5);
    idle(T - 1);
    send_byte(8'h01); idle(2);
    send_byte(8'h10); idle(2);
    send_byte(8'h3C); idle(2);
    send_byte(8'h2D);
    chk_val("edge_valid", 32'(bus.cmd_valid), 32'd1);
    chk_val("edge_no_err", 32'(err_seen - e0), 32'd0);
    tick();
    chk_val("edge_fcnt", 32'(frame_cnt), 32'd7);
    idle(2);

    // Reset mid-frame
    send_byte(8'hA5); idle(2);
    send_byte(8'h01); idle(2);
    send_byte(8'h10); idle(1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    idle(2);
    send_frame(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    chk_val("post_rst_valid", 32'(bus.cmd_valid), 32'd1);
    tick();
    chk_val("post_rst_fcnt", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
